// File: rtl/lieat_lsu_memif_pkg.sv
// Shared encodings for the LSU memory-interface agent: access sizes, flag layout, FSM states.
// The misalignment helper is only referenced when LIEAT_LSU_MEMIF_MISALIGN_CHK_EN is defined.
package lieat_lsu_memif_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    localparam int FLAG_SIZE_LO = 0;
    localparam int FLAG_SIZE_HI = 1;
    localparam int FLAG_USIGN   = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_RSP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_REQ   = ST_REQ,
        S_WAIT  = ST_WAIT,
        S_FLUSH = ST_FLUSH,
        S_RSP   = ST_RSP
    } memif_state_e;

    // size 11 counts as a word access
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == LSU_SIZE_H) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lieat_lsu_memif_align.sv
// Byte-lane steering: store replication/strobes and load shift plus sign/zero extension.
module lieat_lsu_memif_align
    import lieat_lsu_memif_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic [1:0]        size,
    input  logic              usign,
    input  logic [1:0]        off,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   ld_raw,
    output logic [XLEN-1:0]   st_lane,
    output logic [STRB_W-1:0] st_strb,
    output logic [XLEN-1:0]   ld_data
);

    logic [XLEN-1:0] shifted;
    assign shifted = ld_raw >> {off, 3'b000};

    always_comb begin
        st_lane = st_data;
        st_strb = '1;
        ld_data = ld_raw;
        case (size)
            LSU_SIZE_B: begin
                st_lane = {STRB_W{st_data[7:0]}};
                st_strb = STRB_W'(1) << off;
                ld_data = {{(XLEN-8){~usign & shifted[7]}}, shifted[7:0]};
            end
            LSU_SIZE_H: begin
                // strobe shifts past the top lane at off=3 and is simply truncated
                st_lane = {(STRB_W/2){st_data[15:0]}};
                st_strb = STRB_W'(3) << off;
                ld_data = {{(XLEN-16){~usign & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                st_lane = st_data;
                st_strb = '1;
                ld_data = ld_raw;
            end
        endcase
    end

endmodule

// File: rtl/lieat_lsu_memif.sv
// LSU request -> single-beat data-memory transaction, plus fence.i / D-cache flush sequencing.
// Optional misalignment trap and bus-error reporting: LIEAT_LSU_MEMIF_MISALIGN_CHK_EN.
module lieat_lsu_memif
    import lieat_lsu_memif_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_ren,
    input  logic              lsu_req_wen,
    input  logic [XLEN-1:0]   lsu_req_addr,
    input  logic [2:0]        lsu_req_flag,
    input  logic [XLEN-1:0]   lsu_req_wdata,
    input  logic              lsu_req_fencei,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [XLEN-1:0]   lsu_rsp_rdata,
    output logic              lsu_rsp_fencei_over,
`ifdef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
    output logic              lsu_rsp_err,
    input  logic              mem_rsp_err,
`endif
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              dcache_flush_req,
    input  logic              dcache_flush_ack
);

    memif_state_e      state_reg;
    logic [XLEN-1:0]   addr_reg;
    logic [2:0]        flag_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic              ren_reg;
    logic              wen_reg;
    logic              fencei_reg;
    logic [XLEN-1:0]   rdata_reg;
    logic              fencei_over_reg;

    logic [XLEN-1:0]   st_lane;
    logic [STRB_W-1:0] st_strb;
    logic [XLEN-1:0]   ld_data;
    logic              req_misaligned;
    logic              in_req;

`ifdef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
    logic err_reg;
    assign req_misaligned = is_misaligned(lsu_req_flag[FLAG_SIZE_HI:FLAG_SIZE_LO], lsu_req_addr[1:0]);
    assign lsu_rsp_err    = err_reg;
`else
    assign req_misaligned = 1'b0;
`endif

    lieat_lsu_memif_align #(
        .XLEN   (XLEN),
        .STRB_W (STRB_W)
    ) u_align (
        .size    (flag_reg[FLAG_SIZE_HI:FLAG_SIZE_LO]),
        .usign   (flag_reg[FLAG_USIGN]),
        .off     (addr_reg[1:0]),
        .st_data (wdata_reg),
        .ld_raw  (mem_rsp_rdata),
        .st_lane (st_lane),
        .st_strb (st_strb),
        .ld_data (ld_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            addr_reg        <= '0;
            flag_reg        <= '0;
            wdata_reg       <= '0;
            ren_reg         <= 1'b0;
            wen_reg         <= 1'b0;
            fencei_reg      <= 1'b0;
            rdata_reg       <= '0;
            fencei_over_reg <= 1'b0;
`ifdef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
            err_reg         <= 1'b0;
`endif
        end else begin
            fencei_over_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (lsu_req_valid) begin
                        addr_reg   <= lsu_req_addr;
                        flag_reg   <= lsu_req_flag;
                        wdata_reg  <= lsu_req_wdata;
                        fencei_reg <= lsu_req_fencei;
                        // fence.i outranks store, store outranks load
                        wen_reg    <= lsu_req_wen & ~lsu_req_fencei;
                        ren_reg    <= lsu_req_ren & ~lsu_req_wen & ~lsu_req_fencei;
                        rdata_reg  <= '0;
`ifdef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
                        err_reg    <= ~lsu_req_fencei & (lsu_req_ren | lsu_req_wen) & req_misaligned;
`endif
                        if (lsu_req_fencei)
                            state_reg <= S_FLUSH;
                        else if ((lsu_req_ren | lsu_req_wen) && !req_misaligned)
                            state_reg <= S_REQ;
                        else
                            state_reg <= S_RSP;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready)
                        state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_reg <= ren_reg ? ld_data : '0;
`ifdef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
                        err_reg   <= mem_rsp_err;
`endif
                        state_reg <= S_RSP;
                    end
                end
                S_FLUSH: begin
                    if (dcache_flush_ack) begin
                        fencei_over_reg <= 1'b1;
                        state_reg       <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (lsu_rsp_ready)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign in_req = (state_reg == S_REQ);

    assign lsu_req_ready       = (state_reg == S_IDLE);
    assign lsu_rsp_valid       = (state_reg == S_RSP);
    assign lsu_rsp_rdata       = rdata_reg;
    assign lsu_rsp_fencei_over = fencei_over_reg;
    assign dcache_flush_req    = (state_reg == S_FLUSH) & fencei_reg;

    assign mem_req_valid = in_req;
    assign mem_req_wen   = in_req & wen_reg;
    assign mem_req_addr  = in_req ? {addr_reg[XLEN-1:2], 2'b00} : '0;
    assign mem_req_wdata = (in_req & wen_reg) ? st_lane : '0;
    assign mem_req_wstrb = (in_req & wen_reg) ? st_strb : '0;

endmodule

// File: tb/tb_lieat_lsu_memif.sv
// Directed self-checking bench for lieat_lsu_memif; expected values are hand-computed.
module tb_lieat_lsu_memif;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_ren;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_addr;
    logic [2:0]  lsu_req_flag;
    logic [31:0] lsu_req_wdata;
    logic        lsu_req_fencei;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_ready;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_fencei_over;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        dcache_flush_req;
    logic        dcache_flush_ack;
`ifdef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
    logic        lsu_rsp_err;
    logic        mem_rsp_err;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    lieat_lsu_memif dut (
        .clock               (clk),
        .reset               (reset),
        .lsu_req_valid       (lsu_req_valid),
        .lsu_req_ready       (lsu_req_ready),
        .lsu_req_ren         (lsu_req_ren),
        .lsu_req_wen         (lsu_req_wen),
        .lsu_req_addr        (lsu_req_addr),
        .lsu_req_flag        (lsu_req_flag),
        .lsu_req_wdata       (lsu_req_wdata),
        .lsu_req_fencei      (lsu_req_fencei),
        .lsu_rsp_valid       (lsu_rsp_valid),
        .lsu_rsp_ready       (lsu_rsp_ready),
        .lsu_rsp_rdata       (lsu_rsp_rdata),
        .lsu_rsp_fencei_over (lsu_rsp_fencei_over),
`ifdef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
        .lsu_rsp_err         (lsu_rsp_err),
        .mem_rsp_err         (mem_rsp_err),
`endif
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_wen         (mem_req_wen),
        .mem_req_addr        (mem_req_addr),
        .mem_req_wdata       (mem_req_wdata),
        .mem_req_wstrb       (mem_req_wstrb),
        .mem_rsp_valid       (mem_rsp_valid),
        .mem_rsp_rdata       (mem_rsp_rdata),
        .dcache_flush_req    (dcache_flush_req),
        .dcache_flush_ack    (dcache_flush_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp)
            checks_passed++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mem(input string tag, input logic wen, input logic [31:0] addr,
                           input logic [2:0] flag, input logic [31:0] wdata,
                           input logic [31:0] raw, input int stall,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                           input logic [31:0] exp_rdata);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        lsu_req_valid = 1'b1;
        lsu_req_ren   = ~wen;
        lsu_req_wen   = wen;
        lsu_req_addr  = addr;
        lsu_req_flag  = flag;
        lsu_req_wdata = wdata;
        step();
        lsu_req_valid = 1'b0;
        lsu_req_ren   = 1'b0;
        lsu_req_wen   = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            check({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'd1);
            check({tag, ".mem_req_addr"},  mem_req_addr, exp_addr);
            check({tag, ".mem_req_wen"},   32'(mem_req_wen), 32'(wen));
            check({tag, ".mem_req_wdata"}, mem_req_wdata, exp_wdata);
            check({tag, ".mem_req_wstrb"}, 32'(mem_req_wstrb), 32'(exp_strb));
            check({tag, ".req_ready"},     32'(lsu_req_ready), 32'd0);
            if (i == stall) mem_req_ready = 1'b1;
            step();
        end
        mem_req_ready = 1'b0;
        check({tag, ".wait_valid"}, 32'(mem_req_valid), 32'd0);
        check({tag, ".wait_rsp"},   32'(lsu_rsp_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = raw;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        check({tag, ".rsp_valid"}, 32'(lsu_rsp_valid), 32'd1);
        check({tag, ".rsp_rdata"}, lsu_rsp_rdata, exp_rdata);
        lsu_rsp_ready = 1'b1;
        step();
        lsu_rsp_ready = 1'b0;
        check({tag, ".idle_rsp"},   32'(lsu_rsp_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(lsu_req_ready), 32'd1);
        $display("txn %s addr=0x%08h rdata=0x%08h", tag, addr, lsu_rsp_rdata);
    endtask

    initial begin
        reset = 1'b1;
        lsu_req_valid = 1'b0; lsu_req_ren = 1'b0; lsu_req_wen = 1'b0;
        lsu_req_addr = 32'h0; lsu_req_flag = 3'b0; lsu_req_wdata = 32'h0;
        lsu_req_fencei = 1'b0; lsu_rsp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        dcache_flush_ack = 1'b0;
`ifdef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
        mem_rsp_err = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        check("reset.req_ready",     32'(lsu_req_ready), 32'd1);
        check("reset.rsp_valid",     32'(lsu_rsp_valid), 32'd0);
        check("reset.mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("reset.flush_req",     32'(dcache_flush_req), 32'd0);
        check("reset.rdata",         lsu_rsp_rdata, 32'h0);
        $display("txn reset");

        //       tag      wen  addr          flag    wdata         raw           stall exp_wdata     strb     exp_rdata
        run_mem("lb_s",  1'b0, 32'h8000_0003, 3'b000, 32'h0,        32'h80AA_BBCC, 0, 32'h0,        4'b0000, 32'hFFFF_FF80);
        run_mem("sh",    1'b1, 32'h8000_0002, 3'b001, 32'h1234_5678, 32'hDEAD_BEEF, 0, 32'h5678_5678, 4'b1100, 32'h0);
        run_mem("lhu",   1'b0, 32'h8000_0010, 3'b101, 32'h0,        32'h0000_F00D, 4, 32'h0,        4'b0000, 32'h0000_F00D);
        run_mem("lh_s",  1'b0, 32'h8000_0012, 3'b001, 32'h0,        32'h8001_7FFF, 0, 32'h0,        4'b0000, 32'hFFFF_8001);
        run_mem("sb",    1'b1, 32'h8000_0001, 3'b000, 32'h0000_00A5, 32'h0,        1, 32'hA5A5_A5A5, 4'b0010, 32'h0);
        run_mem("sw",    1'b1, 32'h8000_0004, 3'b010, 32'hCAFE_F00D, 32'h0,        0, 32'hCAFE_F00D, 4'b1111, 32'h0);
        run_mem("lbu",   1'b0, 32'h8000_0002, 3'b100, 32'h0,        32'h00F1_0000, 0, 32'h0,        4'b0000, 32'h0000_00F1);
        run_mem("lw_11", 1'b0, 32'h8000_0008, 3'b011, 32'h0,        32'h8765_4321, 0, 32'h0,        4'b0000, 32'h8765_4321);
`ifndef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
        run_mem("sh_off3", 1'b1, 32'h8000_0003, 3'b001, 32'h0000_BEEF, 32'h0,      0, 32'hBEEF_BEEF, 4'b1000, 32'h0);
`endif

        // response back-pressure: rsp_valid and rdata must hold
        lsu_req_valid = 1'b1; lsu_req_ren = 1'b1; lsu_req_addr = 32'h8000_0020; lsu_req_flag = 3'b010;
        step();
        lsu_req_valid = 1'b0; lsu_req_ren = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_BABE;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("stall.rsp_valid", 32'(lsu_rsp_valid), 32'd1);
            check("stall.rdata",     lsu_rsp_rdata, 32'hCAFE_BABE);
            check("stall.req_ready", 32'(lsu_req_ready), 32'd0);
            step();
        end
        lsu_rsp_ready = 1'b1;
        step();
        lsu_rsp_ready = 1'b0;
        check("stall.released", 32'(lsu_req_ready), 32'd1);
        $display("txn stall_lw rdata=0xcafebabe");

        // reset while waiting for the bus response, then a stray response
        lsu_req_valid = 1'b1; lsu_req_ren = 1'b1; lsu_req_addr = 32'h8000_0024; lsu_req_flag = 3'b010;
        step();
        lsu_req_valid = 1'b0; lsu_req_ren = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst.req_ready",     32'(lsu_req_ready), 32'd1);
        check("midrst.rsp_valid",     32'(lsu_rsp_valid), 32'd0);
        check("midrst.mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("midrst.mem_req_addr",  mem_req_addr, 32'h0);
        check("midrst.rdata",         lsu_rsp_rdata, 32'h0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_1111;
        step();
        mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        check("stray.rsp_valid", 32'(lsu_rsp_valid), 32'd0);
        check("stray.req_ready", 32'(lsu_req_ready), 32'd1);
        check("stray.rdata",     lsu_rsp_rdata, 32'h0);
        $display("txn reset_mid_wait");

        // fence.i (store bit also set: fence wins) with ack after 10 flush cycles
        lsu_req_valid = 1'b1; lsu_req_fencei = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_0000;
        step();
        lsu_req_valid = 1'b0; lsu_req_fencei = 1'b0; lsu_req_wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("fence.flush_req", 32'(dcache_flush_req), 32'd1);
            check("fence.req_ready", 32'(lsu_req_ready), 32'd0);
            check("fence.no_bus",    32'(mem_req_valid), 32'd0);
            check("fence.over_low",  32'(lsu_rsp_fencei_over), 32'd0);
            if (i == 9) dcache_flush_ack = 1'b1;
            step();
        end
        dcache_flush_ack = 1'b0;
        check("fence.over_pulse", 32'(lsu_rsp_fencei_over), 32'd1);
        check("fence.flush_drop", 32'(dcache_flush_req), 32'd0);
        check("fence.rsp_valid",  32'(lsu_rsp_valid), 32'd1);
        check("fence.rdata",      lsu_rsp_rdata, 32'h0);
        step();
        check("fence.over_once",  32'(lsu_rsp_fencei_over), 32'd0);
        check("fence.rsp_hold",   32'(lsu_rsp_valid), 32'd1);
        check("fence.req_ready2", 32'(lsu_req_ready), 32'd0);
        lsu_rsp_ready = 1'b1;
        step();
        lsu_rsp_ready = 1'b0;
        $display("txn fence_i");

        // no-op request: one-cycle response, no accept while responding
        lsu_req_valid = 1'b1;
        step();
        check("noop.rsp_valid", 32'(lsu_rsp_valid), 32'd1);
        check("noop.rdata",     lsu_rsp_rdata, 32'h0);
        check("noop.no_bus",    32'(mem_req_valid), 32'd0);
        check("noop.no_accept", 32'(lsu_req_ready), 32'd0);
        lsu_req_valid = 1'b0; lsu_rsp_ready = 1'b1;
        step();
        lsu_rsp_ready = 1'b0;
        check("noop.idle", 32'(lsu_req_ready), 32'd1);
        $display("txn noop");

`ifdef LIEAT_LSU_MEMIF_MISALIGN_CHK_EN
        lsu_req_valid = 1'b1; lsu_req_ren = 1'b1; lsu_req_addr = 32'h8000_0001; lsu_req_flag = 3'b010;
        step();
        lsu_req_valid = 1'b0; lsu_req_ren = 1'b0;
        check("mis.no_bus",    32'(mem_req_valid), 32'd0);
        check("mis.rsp_valid", 32'(lsu_rsp_valid), 32'd1);
        check("mis.err",       32'(lsu_rsp_err), 32'd1);
        check("mis.rdata",     lsu_rsp_rdata, 32'h0);
        lsu_rsp_ready = 1'b1;
        step();
        lsu_rsp_ready = 1'b0;
        $display("txn misaligned_lw");
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
